// File: rtl/regfile_wb_bypass.sv
// 32-entry MIPS register file with write-first bypass on two read ports,
// an unbypassed debug port and a saturating committed-write counter.
module regfile_wb_bypass #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                  Clk,
    input  logic                  Rst,
    input  logic                  RegWrite,
    input  logic [ADDR_WIDTH-1:0] WriteReg,
    input  logic [DATA_WIDTH-1:0] WriteData,
    input  logic [ADDR_WIDTH-1:0] ReadReg1,
    input  logic [ADDR_WIDTH-1:0] ReadReg2,
    output logic [DATA_WIDTH-1:0] ReadData1,
    output logic [DATA_WIDTH-1:0] ReadData2,
    input  logic [ADDR_WIDTH-1:0] DbgReg,
    output logic [DATA_WIDTH-1:0] DbgData,
    output logic [CNT_WIDTH-1:0]  WriteCount
);

    localparam int unsigned NUM_REGS = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] regs [NUM_REGS];
    logic [CNT_WIDTH-1:0]  write_count;
    logic                  commit_c;

    // A write commits only out of reset and never to the hardwired-zero register.
    assign commit_c = Rst && RegWrite && (WriteReg != '0);

    // Register array: flops, cleared asynchronously.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                regs[i] <= '0;
            end
        end else if (commit_c) begin
            regs[WriteReg] <= WriteData;
        end
    end

    // Committed-write counter, sticks at all-ones instead of wrapping.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            write_count <= '0;
        end else if (commit_c && (write_count != '1)) begin
            write_count <= write_count + CNT_WIDTH'(1);
        end
    end

    assign WriteCount = write_count;

    // Read ports: address 0 forces zero, a matching WB write is forwarded.
    always_comb begin
        ReadData1 = '0;
        ReadData2 = '0;
        DbgData   = '0;
        if (ReadReg1 != '0) begin
            ReadData1 = (commit_c && (WriteReg == ReadReg1)) ? WriteData : regs[ReadReg1];
        end
        if (ReadReg2 != '0) begin
            ReadData2 = (commit_c && (WriteReg == ReadReg2)) ? WriteData : regs[ReadReg2];
        end
        if (DbgReg != '0) begin
            DbgData = regs[DbgReg];
        end
    end

endmodule

// File: tb/tb_regfile_wb_bypass.sv
// Directed bench for regfile_wb_bypass: expectations are queued by the
// stimulus and compared at the following falling clock edge.
module tb_regfile_wb_bypass;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 5;
    localparam int unsigned CW = 4;

    logic          Clk = 1'b0;
    logic          Rst;
    logic          RegWrite;
    logic [AW-1:0] WriteReg;
    logic [DW-1:0] WriteData;
    logic [AW-1:0] ReadReg1;
    logic [AW-1:0] ReadReg2;
    logic [DW-1:0] ReadData1;
    logic [DW-1:0] ReadData2;
    logic [AW-1:0] DbgReg;
    logic [DW-1:0] DbgData;
    logic [CW-1:0] WriteCount;

    regfile_wb_bypass #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
        .Clk(Clk), .Rst(Rst), .RegWrite(RegWrite), .WriteReg(WriteReg),
        .WriteData(WriteData), .ReadReg1(ReadReg1), .ReadReg2(ReadReg2),
        .ReadData1(ReadData1), .ReadData2(ReadData2), .DbgReg(DbgReg),
        .DbgData(DbgData), .WriteCount(WriteCount)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        string       name;
        int          sel;    // 0 ReadData1, 1 ReadData2, 2 DbgData, 3 WriteCount
        logic [31:0] value;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Scoreboard monitor: outputs are stable mid-cycle.
    always @(negedge Clk) begin
        while (exp_q.size() > 0) begin
            exp_t e;
            logic [31:0] act;
            e = exp_q.pop_front();
            case (e.sel)
                0:       act = ReadData1;
                1:       act = ReadData2;
                2:       act = DbgData;
                default: act = 32'(WriteCount);
            endcase
            checks++;
            if (act !== e.value) begin
                errors++;
                $display("FAIL %s: got %h expected %h", e.name, act, e.value);
            end
        end
    end

    task automatic push(input string name, input int sel, input logic [31:0] v);
        exp_t e;
        e.name = name; e.sel = sel; e.value = v;
        exp_q.push_back(e);
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic drive(input logic we, input logic [AW-1:0] wr, input logic [DW-1:0] wd,
                         input logic [AW-1:0] r1, input logic [AW-1:0] r2, input logic [AW-1:0] dr);
        RegWrite = we; WriteReg = wr; WriteData = wd;
        ReadReg1 = r1; ReadReg2 = r2; DbgReg = dr;
    endtask

    task automatic expect4(input string name, input logic [31:0] e1, input logic [31:0] e2,
                           input logic [31:0] ed, input logic [31:0] ec);
        push({name, ".rd1"}, 0, e1);
        push({name, ".rd2"}, 1, e2);
        push({name, ".dbg"}, 2, ed);
        push({name, ".cnt"}, 3, ec);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        Rst = 1'b0;
        drive(1'b0, '0, '0, '0, '0, '0);

        // Held in reset: every address reads 0 and writes are ignored.
        for (int a = 0; a < 32; a++) begin
            step();
            drive(1'b1, AW'(a), 32'hFFFF_FFFF, AW'(a), AW'(31 - a), AW'(a));
            expect4($sformatf("rst_r%0d", a), 32'h0, 32'h0, 32'h0, 32'h0);
        end

        // Release between edges; the first write commits on the next edge.
        step();
        Rst = 1'b1;
        drive(1'b1, 5'd8, 32'hDEAD_BEEF, 5'd8, 5'd0, 5'd8);
        expect4("wr8_byp", 32'hDEAD_BEEF, 32'h0, 32'h0, 32'h0);
        step();
        drive(1'b0, 5'd0, 32'h0, 5'd8, 5'd8, 5'd8);
        expect4("rd8", 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'h1);

        // Same-cycle bypass on both ports; debug port shows the old value.
        step();
        drive(1'b1, 5'd9, 32'h1, 5'd0, 5'd0, 5'd0);
        step();
        drive(1'b1, 5'd9, 32'h55AA, 5'd9, 5'd9, 5'd9);
        expect4("byp9", 32'h55AA, 32'h55AA, 32'h1, 32'h2);
        step();
        drive(1'b0, 5'd0, 32'h0, 5'd9, 5'd8, 5'd9);
        expect4("after9", 32'h55AA, 32'hDEAD_BEEF, 32'h55AA, 32'h3);

        // jal link register, then a discarded write to r0.
        step();
        drive(1'b1, 5'd31, 32'h0040_0010, 5'd0, 5'd0, 5'd0);
        step();
        drive(1'b1, 5'd0, 32'hFFFF_FFFF, 5'd0, 5'd31, 5'd0);
        expect4("wr0_byp", 32'h0, 32'h0040_0010, 32'h0, 32'h4);
        step();
        drive(1'b0, 5'd0, 32'h0, 5'd0, 5'd31, 5'd31);
        expect4("rd0", 32'h0, 32'h0040_0010, 32'h0040_0010, 32'h4);

        // Back-to-back writes interrupted by an async reset between edges.
        step();
        drive(1'b1, 5'd1, 32'h11, 5'd0, 5'd0, 5'd0);
        step();
        drive(1'b1, 5'd2, 32'h22, 5'd1, 5'd0, 5'd1);
        expect4("pre_rst", 32'h11, 32'h0, 32'h11, 32'h5);
        step();
        drive(1'b1, 5'd3, 32'h33, 5'd3, 5'd2, 5'd8);
        #2;
        Rst = 1'b0;
        expect4("mid_rst", 32'h0, 32'h0, 32'h0, 32'h0);
        step();
        expect4("rst_held", 32'h0, 32'h0, 32'h0, 32'h0);
        step();
        Rst = 1'b1;
        drive(1'b1, 5'd4, 32'h44, 5'd4, 5'd3, 5'd3);
        expect4("post_rst_byp", 32'h44, 32'h0, 32'h0, 32'h0);
        step();
        drive(1'b0, 5'd0, 32'h0, 5'd4, 5'd3, 5'd4);
        expect4("post_rst", 32'h44, 32'h0, 32'h44, 32'h1);

        // Counter saturation over 20 writes.
        step();
        Rst = 1'b0;
        step();
        Rst = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            drive(1'b1, AW'(i), 32'h1000 + 32'(i), 5'd0, 5'd0, 5'd0);
            push($sformatf("sat_cnt%0d", i), 3, (i - 1 > 15) ? 32'd15 : 32'(i - 1));
            step();
        end
        drive(1'b1, 5'd0, 32'hFFFF_FFFF, 5'd0, 5'd0, 5'd0);
        push("sat_final", 3, 32'd15);
        step();
        for (int i = 1; i <= 20; i++) begin
            drive(1'b0, 5'd0, 32'h0, AW'(i), AW'(21 - i), AW'(i));
            expect4($sformatf("sat_r%0d", i), 32'h1000 + 32'(i), 32'h1000 + 32'(21 - i),
                    32'h1000 + 32'(i), 32'd15);
            step();
        end

        step();
        step();
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL queue_drain: got %0d pending expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
